// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared state encoding and stall counter width for the system ID checker
package sysid_pkg;

    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ID  = 2'd1,
        ST_RD_TS  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/sysid_stall_timer.sv
// rtl/sysid_stall_timer.sv - counts waitrequest-stalled cycles of one read and flags the limit
module sysid_stall_timer
    import sysid_pkg::*;
(
    input  logic               clock,
    input  logic               clear,
    input  logic               enable,
    input  logic [STALL_W-1:0] limit,
    output logic               expired
);

    logic [STALL_W-1:0] r_count;
    logic [STALL_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, r_count} + (STALL_W + 1)'(1);

    // Expires in the stalled cycle that would bring the count up to the limit.
    assign expired = enable && (w_count_inc >= {1'b0, limit});

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_count_inc[STALL_W-1:0];
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads the system ID and build timestamp words and compares them to expected values
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h12345678,
    parameter logic [31:0] EXPECTED_TS    = 32'h5CDB1F3E,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_auto_pending;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        w_launch;
    logic        w_in_read;
    logic        w_stall_en;
    logic        w_stall_clear;
    logic        w_stall_expired;
    logic        w_ts_match;

    assign w_in_read     = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    assign w_stall_en    = w_in_read && avm_waitrequest;
    assign w_stall_clear = reset || (r_state != w_next_state);
    assign w_ts_match    = (avm_readdata == EXPECTED_TS);

    sysid_stall_timer u_stall_timer (
        .clock   (clock),
        .clear   (w_stall_clear),
        .enable  (w_stall_en),
        .limit   (LIMIT),
        .expired (w_stall_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        avm_read     = 1'b0;
        avm_address  = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start || r_auto_pending) begin
                    w_next_state = ST_RD_ID;
                    w_launch     = 1'b1;
                end
            end
            ST_RD_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    w_next_state = ST_RD_TS;
                end else if (w_stall_expired) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest || w_stall_expired) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // pass is resolved on entry to FINISH so it is already valid alongside done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_auto_pending <= (AUTO_START != 0);
            r_pass         <= 1'b0;
            r_id_ok        <= 1'b0;
            r_ts_ok        <= 1'b0;
            r_timeout      <= 1'b0;
            r_id_value     <= '0;
            r_ts_value     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_launch) begin
                r_auto_pending <= 1'b0;
                r_pass         <= 1'b0;
                r_id_ok        <= 1'b0;
                r_ts_ok        <= 1'b0;
                r_timeout      <= 1'b0;
                r_id_value     <= '0;
                r_ts_value     <= '0;
            end
            case (r_state)
                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        r_id_value <= avm_readdata;
                        r_id_ok    <= (avm_readdata == EXPECTED_ID);
                    end else if (w_stall_expired) begin
                        r_timeout <= 1'b1;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        r_ts_value <= avm_readdata;
                        r_ts_ok    <= w_ts_match;
                        r_pass     <= r_id_ok && w_ts_match;
                    end else if (w_stall_expired) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pass     = r_pass;
    assign id_ok    = r_id_ok;
    assign ts_ok    = r_ts_ok;
    assign timeout  = r_timeout;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - randomized self-checking bench for sysid_checker against a cycle-count model
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h12345678;
    localparam logic [31:0] EXP_TS = 32'h5CDB1F3E;
    localparam int          TMO    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int n_checks = 0;
    int n_errors = 0;

    int          cfg_stall [2];
    logic [31:0] cfg_data  [2];
    int          slv_cnt = 0;
    logic        slv_prev_read = 1'b0;
    logic        slv_prev_addr = 1'b0;

    sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO),
        .AUTO_START     (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    // Slave: each new read access stalls for cfg_stall[address] cycles, then returns cfg_data[address].
    always @(negedge clock) begin
        if (!avm_read) begin
            slv_cnt         = 0;
            avm_waitrequest = 1'b0;
        end else begin
            if (!slv_prev_read || (avm_address != slv_prev_addr)) slv_cnt = 0;
            avm_waitrequest = (slv_cnt < cfg_stall[avm_address]);
            avm_readdata    = cfg_data[avm_address];
            slv_cnt++;
        end
        slv_prev_read = avm_read;
        slv_prev_addr = avm_address;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, {24'd0, avm_read, avm_address, busy, done, pass, id_ok, ts_ok, timeout}, 32'd0);
        chk({tag, "_id_value"}, id_value, 32'd0);
        chk({tag, "_ts_value"}, ts_value, 32'd0);
    endtask

    // Called at a negedge; the following posedge is the edge that launches the check.
    task automatic run_check(input bit use_start, input int sid, input int sts,
                             input logic [31:0] idw, input logic [31:0] tsw, input bit extra_start);
        int          exp_cycles;
        int          id_len;
        bit          exp_to, e_idok, e_tsok, e_pass, seen;
        logic [31:0] e_idv, e_tsv;

        if (sid >= TMO) begin
            exp_to = 1; id_len = TMO; exp_cycles = TMO + 1;
            e_idv = 0; e_idok = 0; e_tsv = 0; e_tsok = 0;
        end else begin
            id_len = sid + 1; e_idv = idw; e_idok = (idw == EXP_ID);
            if (sts >= TMO) begin
                exp_to = 1; exp_cycles = id_len + TMO + 1; e_tsv = 0; e_tsok = 0;
            end else begin
                exp_to = 0; exp_cycles = id_len + sts + 2; e_tsv = tsw; e_tsok = (tsw == EXP_TS);
            end
        end
        e_pass = e_idok && e_tsok && !exp_to;

        cfg_stall[0] = sid; cfg_stall[1] = sts;
        cfg_data[0]  = idw; cfg_data[1]  = tsw;
        start = use_start;
        reset = 1'b0;
        seen  = 0;
        for (int k = 1; k <= exp_cycles + 5 && !seen; k++) begin
            @(negedge clock);
            start = extra_start && (k == exp_cycles - 1 || k == exp_cycles);
            if (done) begin
                seen = 1;
                chk("done_cycle", k, exp_cycles);
                chk("read_in_finish", {31'd0, avm_read}, 32'd0);
            end else if (k < exp_cycles) begin
                chk("read_active", {31'd0, avm_read}, 32'd1);
                chk("address", {31'd0, avm_address}, (k <= id_len) ? 32'd0 : 32'd1);
                chk("busy_active", {31'd0, busy}, 32'd1);
            end
        end
        if (!seen) chk("done_seen", 32'd0, 32'd1);
        chk("id_ok", {31'd0, id_ok}, {31'd0, e_idok});
        chk("ts_ok", {31'd0, ts_ok}, {31'd0, e_tsok});
        chk("pass", {31'd0, pass}, {31'd0, e_pass});
        chk("timeout", {31'd0, timeout}, {31'd0, exp_to});
        chk("id_value", id_value, e_idv);
        chk("ts_value", ts_value, e_tsv);
        @(negedge clock);
        start = 1'b0;
        chk("pass_sticky", {31'd0, pass}, {31'd0, e_pass});
        chk("busy_idle", {31'd0, busy}, 32'd0);
        if (extra_start) begin
            repeat (3) begin
                @(negedge clock);
                chk("no_second_done", {30'd0, done, busy}, 32'd0);
            end
        end
    endtask

    function automatic logic [31:0] pick_word(input logic [31:0] good);
        logic [31:0] w;
        w = good;
        if ($urandom_range(0, 1) == 0) w = good ^ (32'd1 << $urandom_range(0, 31));
        return w;
    endfunction

    initial begin
        cfg_stall[0] = 0; cfg_stall[1] = 0;
        cfg_data[0]  = EXP_ID; cfg_data[1] = EXP_TS;
        repeat (3) @(negedge clock);
        chk_all_zero("reset_state");

        run_check(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b0);
        run_check(1'b1, 0, 0, 32'h12345679, EXP_TS, 1'b0);
        run_check(1'b1, 4, 4, EXP_ID, EXP_TS, 1'b0);
        run_check(1'b1, 1000, 0, EXP_ID, EXP_TS, 1'b0);
        run_check(1'b1, TMO - 1, TMO - 1, EXP_ID, EXP_TS, 1'b0);
        run_check(1'b1, 2, TMO, EXP_ID, EXP_TS, 1'b0);
        run_check(1'b1, 1, 1, EXP_ID, EXP_TS, 1'b1);
        run_check(1'b1, 0, 0, EXP_ID, 32'h0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_check(1'b1, $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1),
                      pick_word(EXP_ID), pick_word(EXP_TS), 1'b0);
        end

        cfg_stall[0] = 0; cfg_stall[1] = 100;
        cfg_data[0]  = EXP_ID; cfg_data[1] = EXP_TS;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("stalled_in_ts", {30'd0, avm_read, avm_address}, 32'd3);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("reset_mid_read");
        @(negedge clock);
        chk("no_done_in_reset", {31'd0, done}, 32'd0);
        run_check(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
